// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : display_scanner
// Brief    : Time-multiplexed BCD digit scanner with a double-buffered value,
//            anti-ghosting dead time and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module display_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int DEAD     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [3:0]            digit_code,
    output logic [DIGITS-1:0]     digit_enable,
    output logic                  frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [4*DIGITS-1:0]   r_disp;
    logic [3:0]            r_code;
    logic [DIGITS-1:0]     r_en;
    logic                  r_frame;

    logic                  w_slot_end;
    logic                  w_boundary;
    logic [CW-1:0]         w_cnt_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [4*DIGITS-1:0]   w_shadow_nxt;
    logic [4*DIGITS-1:0]   w_disp_nxt;
    logic [3:0]            w_nibble;
    logic                  w_upper_zero;
    logic [3:0]            w_code_nxt;
    logic                  w_dead;
    logic [DIGITS-1:0]     w_en_nxt;

    // Slot/frame counters; all outputs below are derived from next-state values
    always_comb begin
        w_slot_end   = (r_cnt == c_CNT_LAST);
        w_boundary   = w_slot_end && (r_idx == c_IDX_LAST);
        w_cnt_nxt    = w_slot_end ? '0 : r_cnt + CW'(1);
        if (!w_slot_end)
            w_idx_nxt = r_idx;
        else if (r_idx == c_IDX_LAST)
            w_idx_nxt = '0;
        else
            w_idx_nxt = r_idx + IW'(1);
        w_shadow_nxt = load ? value_in : r_shadow;
        w_disp_nxt   = w_boundary ? w_shadow_nxt : r_disp;
    end

    // Select the scanned nibble and detect whether it and all higher ones are zero
    always_comb begin
        w_nibble     = 4'h0;
        w_upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == w_idx_nxt)
                w_nibble = w_disp_nxt[4*i +: 4];
            if ((i >= int'(w_idx_nxt)) && (w_disp_nxt[4*i +: 4] != 4'h0))
                w_upper_zero = 1'b0;
        end
        if (blank_lz && (w_idx_nxt != '0) && w_upper_zero)
            w_code_nxt = 4'hF;
        else
            w_code_nxt = w_nibble;
    end

    generate
        if (DEAD > 0) begin : g_dead
            assign w_dead = (w_cnt_nxt < CW'(DEAD));
        end else begin : g_no_dead
            assign w_dead = 1'b0;
        end
    endgenerate

    assign w_en_nxt = w_dead ? '0 : (DIGITS'(1) << w_idx_nxt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_disp   <= '0;
            r_code   <= 4'h0;
            r_en     <= '0;
            r_frame  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_shadow_nxt;
            r_disp   <= w_disp_nxt;
            r_code   <= w_code_nxt;
            r_en     <= w_en_nxt;
            r_frame  <= w_boundary;
        end
    end

    assign digit_code   = r_code;
    assign digit_enable = r_en;
    assign frame_done   = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scanner
// Brief    : Directed self-checking bench for display_scanner (4 digits,
//            4-cycle slots, 1-cycle dead time).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  digit_code;
    logic [3:0]  digit_enable;
    logic        frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    display_scanner #(
        .DIGITS   (4),
        .PRESCALE (4),
        .DEAD     (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .value_in     (value_in),
        .load         (load),
        .blank_lz     (blank_lz),
        .digit_code   (digit_code),
        .digit_enable (digit_enable),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks ncyc cycles of a frame starting at its first cycle; codes holds the
    // expected code per digit (nibble i = digit i). Optional load / blank_lz
    // changes are applied during the cycle with the given in-frame index.
    task automatic run_frame(input logic [15:0] codes, input logic fd0, input int ncyc,
                             input int load_at, input logic [15:0] load_val,
                             input int blank_at, input logic blank_val);
        logic [3:0] exp_en;
        int idx;
        for (int j = 0; j < ncyc; j++) begin
            idx    = j / 4;
            exp_en = (j % 4 == 0) ? 4'b0000 : (4'b0001 << idx);
            check($sformatf("enable[j=%0d]", j), 32'(digit_enable), 32'(exp_en));
            check($sformatf("code[j=%0d]", j), 32'(digit_code), 32'(codes[4*idx +: 4]));
            check($sformatf("frame_done[j=%0d]", j), 32'(frame_done), 32'((j == 0) ? fd0 : 1'b0));
            if (j == load_at) begin
                load     = 1'b1;
                value_in = load_val;
            end
            if (j == blank_at)
                blank_lz = blank_val;
            step();
            load     = 1'b0;
            value_in = 16'hDEAD;
        end
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        blank_lz = 1'b0;
        value_in = 16'h0000;
        #1;
        check("reset_code", 32'(digit_code), 32'h0);
        check("reset_enable", 32'(digit_enable), 32'h0);
        check("reset_frame", 32'(frame_done), 32'h0);
        step();
        step();
        reset = 1'b0;

        // Frame 1: no frame pulse after reset, load 1234 mid-frame (cycle 5)
        run_frame(16'h0000, 1'b0, 16, 5, 16'h1234, -1, 1'b0);
        // Frame 2: shows 1234; load 5678 in the boundary cycle
        run_frame(16'h1234, 1'b1, 16, 15, 16'h5678, -1, 1'b0);
        // Frame 3: 5678 immediately; load 0050, enable blanking at the boundary
        run_frame(16'h5678, 1'b1, 16, 2, 16'h0050, 15, 1'b1);
        // Frame 4: 0050 blanked -> 0,5,F,F; load 0000
        run_frame(16'hFF50, 1'b1, 16, 3, 16'h0000, -1, 1'b0);
        // Frame 5: 0000 blanked -> 0,F,F,F; load 00A0, disable blanking
        run_frame(16'hFFF0, 1'b1, 16, 4, 16'h00A0, 15, 1'b0);
        // Frame 6: invalid BCD nibble passes through; load 0000
        run_frame(16'h00A0, 1'b1, 16, 0, 16'h0000, -1, 1'b0);
        // Frame 7: zeros without blanking; load 1234
        run_frame(16'h0000, 1'b1, 16, 7, 16'h1234, -1, 1'b0);
        // Frame 8: partial, stop in digit 2 with its enable active
        run_frame(16'h1234, 1'b1, 9, -1, 16'h0000, -1, 1'b0);
        check("pre_async_enable", 32'(digit_enable), 32'b0100);
        check("pre_async_code", 32'(digit_code), 32'h2);

        #3;
        reset = 1'b1;
        #1;
        check("async_code", 32'(digit_code), 32'h0);
        check("async_enable", 32'(digit_enable), 32'h0);
        check("async_frame", 32'(frame_done), 32'h0);
        step();
        reset = 1'b0;

        // Restart from digit 0 with cleared value, no frame pulse at restart
        run_frame(16'h0000, 1'b0, 16, -1, 16'h0000, -1, 1'b0);
        check("restart_frame_done", 32'(frame_done), 32'h1);
        check("restart_enable", 32'(digit_enable), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed digit scanner that sits directly upstream of the Display_Decoder. It holds a multi-digit BCD value and cycles through the digits at a programmable rate. For each digit it presents one 4-bit code, which feeds the decoder's `input_code`, together with a one-hot digit enable that drives the common lines of the display. Value updates are double-buffered so that a frame never tears, and optional leading-zero blanking is supported.

## Interface
Parameters:
- `DIGITS`, default 4: number of digits; legal range 1..8.
- `PRESCALE`, default 1000: clock cycles per digit slot; must be at least 2.
- `DEAD`, default 16: cycles at the start of each slot during which no digit is enabled (anti-ghosting); legal range 0..PRESCALE-1.

Ports:
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `value_in`, input, 4*DIGITS: BCD value; nibble i is digit i, and digit 0 is least significant.
- `load`, input, 1: when high at a clock edge, `value_in` is captured into the shadow register.
- `blank_lz`, input, 1: leading-zero blanking enable; sampled live.
- `digit_code`, output, 4: code for the currently scanned digit, connected to the decoder's `input_code`.
- `digit_enable`, output, DIGITS: one-hot, active-high enable for the current digit.
- `frame_done`, output, 1: one-cycle pulse in the first cycle of each new frame.

## Operation
State registers:
- `cnt`: counts 0..PRESCALE-1.
- `idx`: counts 0..DIGITS-1.
- `shadow`: 4*DIGITS bits, holds the most recently loaded value.
- `disp`: 4*DIGITS bits, holds the value currently being shown.

Slot and frame advance:
- `cnt` increments every cycle.
- At `cnt==PRESCALE-1`, `cnt` wraps to 0 and `idx` advances.
- `idx` wraps from DIGITS-1 to 0.
- The cycle with `cnt==PRESCALE-1` and `idx==DIGITS-1` is the frame boundary B.

Load and display update:
- `load` at any edge writes `shadow <= value_in`.
- At the edge ending B, `disp <= load ? value_in : shadow`. A load coinciding with B is therefore shown immediately in the next frame.
- `disp` never changes at any other time.

Digit code:
- Normally `digit_code = disp[4*idx+3 : 4*idx]`.
- If `blank_lz==1`, `idx>0` and nibbles idx..DIGITS-1 of `disp` are all zero, then `digit_code = 4'b1111`. The decoder's default branch turns this code into all segments off.
- Digit 0 is never blanked, so a value of 0 displays as a single "0".
- Nibbles above 9 pass through unmodified; the decoder blanks them.

Digit enable:
- `digit_enable = 0` while `cnt < DEAD`.
- Otherwise `digit_enable` is one-hot with bit `idx` set.
- Blanked digits still receive their enable; the blanking comes from the code alone.

Frame pulse:
- `frame_done` is high only in the cycle with `cnt==0` and `idx==0` that follows a B.
- It is not asserted in the first cycle after reset.

Reset (asynchronous, immediate, no clock required):
- `cnt`, `idx`, `shadow` and `disp` clear to 0.
- `digit_code` resets to 4'b0000, `digit_enable` to 0, and `frame_done` to 0.

## Timing
- All outputs are registered and computed from next-state values. They are therefore consistent with `cnt` and `idx` in the same cycle and glitch-free.
- Slot length is exactly PRESCALE cycles; frame length is DIGITS*PRESCALE cycles.
- Per slot, `digit_enable` is low for DEAD cycles, then high for PRESCALE-DEAD cycles.
- Load-to-display latency is from the load edge to the next B edge, at most DIGITS*PRESCALE cycles.
- `blank_lz` changes take effect on the next registered output update, one cycle later.
- If `reset` is asserted mid-slot or mid-frame, scanning restarts from digit 0 with `cnt==0` on the first edge after release. Any pending shadow value is lost.
- With `DEAD==0`, an enable is asserted in every cycle.
- With `DIGITS==1`, `idx` stays at 0 and B occurs every PRESCALE cycles.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, DEAD=1.
- Reset: pulse `reset`, then release. `digit_enable` follows the repeating sequence 0000, then 0001 for 3 cycles, then 0000, then 0010 for 3 cycles, and so on. `digit_code` stays 0. The first `frame_done` appears 16 cycles after release.
- Load mid-frame: load 16'h1234 at cycle 5. Digit codes stay 0 until `frame_done`, then read 4, 3, 2, 1 on enables 0001, 0010, 0100 and 1000.
- Load on a boundary: load 16'h5678 in a B cycle. The very next frame shows 8, 7, 6, 5.
- Leading-zero blanking: with `blank_lz=1` and `disp=16'h0050`, codes are 0, 5, F, F. With `disp=16'h0000`, codes are 0, F, F, F. With `blank_lz=0`, codes are 0, 0, 0, 0.
- Invalid BCD: load 16'h00A0 with `blank_lz=0`. The digit 1 code is 4'hA.
- Asynchronous reset mid-slot: assert `reset` between clock edges while `digit_enable=0100`. All outputs go to 0 before the next edge, and after release the scan restarts at digit 0.
